rotary_encoder_param_ctrl: RTL and testbench

- Shares one rotary_encoder counter among NUM_PARAMS stored parameter registers.
- An encoder push-button press rotates the selection to the next parameter. The block then re-initialises the encoder counter from that parameter's stored value and mirrors the encoder's counter_out back into the selected register.
- A host write port can also set any parameter. Sits between the encoder instance and the application registers.

---
 rtl/rotary_encoder_param_ctrl_if.sv | 41 ++++
 rtl/rotary_encoder_param_ctrl.sv | 155 +++++++++++++++
 tb/tb_rotary_encoder_param_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rotary_encoder_param_ctrl_if.sv
// Signal bundle between the parameter controller, the rotary encoder
// instance and the host/application side. The controller uses the slave
// view; whatever drives the encoder inputs and the host port uses master.
interface rotary_encoder_param_ctrl_if #(
  parameter int COUNTER_BITS = 8,
  parameter int NUM_PARAMS   = 4
) ();

  localparam int IDX_BITS = $clog2(NUM_PARAMS);

  // Encoder side
  logic                             sw_n;
  logic [COUNTER_BITS-1:0]          counter_out;
  logic                             counter_init;
  logic [COUNTER_BITS-1:0]          counter_in;

  // Host write port
  logic                             host_wr;
  logic [IDX_BITS-1:0]              host_idx;
  logic [COUNTER_BITS-1:0]          host_data;

  // Application-facing status
  logic [IDX_BITS-1:0]              sel_idx;
  logic [NUM_PARAMS*COUNTER_BITS-1:0] params;
  logic                             param_changed;
  logic [IDX_BITS-1:0]              changed_idx;
  logic                             busy;

  modport master (
    output sw_n, counter_out, host_wr, host_idx, host_data,
    input  counter_init, counter_in, sel_idx, params,
           param_changed, changed_idx, busy
  );

  modport slave (
    input  sw_n, counter_out, host_wr, host_idx, host_data,
    output counter_init, counter_in, sel_idx, params,
           param_changed, changed_idx, busy
  );

endinterface

// File: rtl/rotary_encoder_param_ctrl.sv
// Multiplexes one rotary encoder counter across NUM_PARAMS parameter
// registers. A button press selects the next parameter, reloads the encoder
// from it, and from then on the encoder value is mirrored into that register.
// A host port may overwrite any register at any time.
module rotary_encoder_param_ctrl #(
  parameter int COUNTER_BITS = 8,
  parameter int NUM_PARAMS   = 4,
  parameter int INIT_VALUE   = 0,
  parameter int LOAD_SETTLE  = 2
) (
  input  logic clk,
  input  logic reset,
  rotary_encoder_param_ctrl_if.slave bus
);

  localparam int IDX_BITS = $clog2(NUM_PARAMS);
  localparam int CNT_BITS = (LOAD_SETTLE > 1) ? $clog2(LOAD_SETTLE) : 1;

  localparam logic [IDX_BITS-1:0]     LAST_IDX     = IDX_BITS'(NUM_PARAMS - 1);
  localparam logic [COUNTER_BITS-1:0] INIT_VAL     = COUNTER_BITS'(INIT_VALUE);
  localparam logic [CNT_BITS-1:0]     SETTLE_START = CNT_BITS'(LOAD_SETTLE - 1);

  typedef enum logic [1:0] {
    ST_LOAD,    // strobe counter_init, encoder takes counter_in
    ST_SETTLE,  // encoder output not yet trustworthy
    ST_TRACK    // mirror encoder output into the selected register
  } state_t;

  state_t                  state_q,  state_d;
  logic [CNT_BITS-1:0]     settle_q, settle_d;
  logic [IDX_BITS-1:0]     sel_q,    sel_d;
  logic [COUNTER_BITS-1:0] param_q [NUM_PARAMS];
  logic [COUNTER_BITS-1:0] param_d [NUM_PARAMS];
  logic                    sw_q;
  logic                    changed_q,     changed_d;
  logic [IDX_BITS-1:0]     changed_idx_q, changed_idx_d;

  logic press;
  logic host_valid;
  logic host_hit;
  logic host_change;
  logic mirror;

  // Falling edge of the debounced button; a held button yields one event.
  assign press = sw_q & ~bus.sw_n;

  // Host writes beyond NUM_PARAMS (non power-of-two counts) are ignored.
  assign host_valid  = bus.host_wr && (int'(bus.host_idx) < NUM_PARAMS);
  assign host_hit    = host_valid && (bus.host_idx == sel_q);
  assign host_change = host_valid && (param_q[bus.host_idx] != bus.host_data);

  // Mirror only in TRACK, never in a press cycle, and the host wins a
  // collision on the selected register.
  assign mirror = (state_q == ST_TRACK) && !press && !host_hit &&
                  (bus.counter_out != param_q[sel_q]);

  // Next-state, register updates and change reporting.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    settle_d      = settle_q;
    sel_d         = sel_q;
    param_d       = param_q;
    changed_d     = 1'b0;
    changed_idx_d = changed_idx_q;

    if (host_valid) begin
      param_d[bus.host_idx] = bus.host_data;
    end
    if (mirror) begin
      param_d[sel_q] = bus.counter_out;
    end

    // The selected-register mirror takes the change flag if both land.
    if (mirror) begin
      changed_d     = 1'b1;
      changed_idx_d = sel_q;
    end else if (host_change) begin
      changed_d     = 1'b1;
      changed_idx_d = bus.host_idx;
    end

    unique case (state_q)
      ST_LOAD: begin
        state_d  = ST_SETTLE;
        settle_d = SETTLE_START;
      end
      ST_SETTLE: begin
        if (settle_q == '0) begin
          state_d = ST_TRACK;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      ST_TRACK: begin
        if (press) begin
          sel_d   = (sel_q == LAST_IDX) ? '0 : sel_q + 1'b1;
          state_d = ST_LOAD;
        end
      end
      default: state_d = ST_LOAD;
    endcase

    // A host write to the selected register forces the encoder to reload.
    if (host_hit) begin
      state_d = ST_LOAD;
    end
  end

  // State and register file, synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    if (reset) begin
      state_q       <= ST_LOAD;
      settle_q      <= '0;
      sel_q         <= '0;
      sw_q          <= 1'b1;
      changed_q     <= 1'b0;
      changed_idx_q <= '0;
      // NOTE: the parameter array is a small register file with a defined
      // power-up value, so it is reset explicitly rather than left as RAM.
      for (int k = 0; k < NUM_PARAMS; k++) begin
        param_q[k] <= INIT_VAL;
      end
    end else begin
      state_q       <= state_d;
      settle_q      <= settle_d;
      sel_q         <= sel_d;
      sw_q          <= bus.sw_n;
      changed_q     <= changed_d;
      changed_idx_q <= changed_idx_d;
      param_q       <= param_d;
    end
  end

  // Flatten the register file onto the params bus.
  always_comb begin
    bus.params = '0;
    for (int k = 0; k < NUM_PARAMS; k++) begin
      bus.params[k*COUNTER_BITS +: COUNTER_BITS] = param_q[k];
    end
  end

  // The load strobe is suppressed while reset is held so it only fires in
  // the first LOAD cycle after release.
  assign bus.counter_init  = (state_q == ST_LOAD) && !reset;
  assign bus.busy          = (state_q != ST_TRACK);
  assign bus.counter_in    = param_q[sel_q];
  assign bus.sel_idx       = sel_q;
  assign bus.param_changed = changed_q;
  assign bus.changed_idx   = changed_idx_q;

endmodule

// File: tb/tb_rotary_encoder_param_ctrl.sv
// Self-checking bench for rotary_encoder_param_ctrl: directed scenarios with
// literal expectations, then randomized traffic compared every cycle against
// a behavioural model that tracks "cycles since the last encoder load".
module tb_rotary_encoder_param_ctrl;

  localparam int CB   = 8;
  localparam int NP   = 4;
  localparam int INIT = 0;
  localparam int LS   = 2;
  localparam int IW   = $clog2(NP);

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  rotary_encoder_param_ctrl_if #(.COUNTER_BITS(CB), .NUM_PARAMS(NP)) bus ();

  rotary_encoder_param_ctrl #(
    .COUNTER_BITS(CB),
    .NUM_PARAMS  (NP),
    .INIT_VALUE  (INIT),
    .LOAD_SETTLE (LS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Load/settle/track is represented only as the number of cycles since the
  // last encoder load: 0 is the load cycle, 1..LS settling, beyond that
  // the encoder value is tracked.
  int m_param [NP];
  int m_sel;
  int m_since;
  bit m_sw_prev;
  bit m_chg;
  int m_chg_idx;
  bit model_ok = 1'b0;

  always @(posedge clk) begin : model
    bit press, tracking, hit, mir, hchg;
    int hi, co;
    if (reset) begin
      for (int k = 0; k < NP; k++) m_param[k] = INIT;
      m_sel     = 0;
      m_since   = 0;
      m_sw_prev = 1'b1;
      m_chg     = 1'b0;
      m_chg_idx = 0;
    end else begin
      hi        = int'(bus.host_idx);
      co        = int'(bus.counter_out);
      press     = m_sw_prev && !bus.sw_n;
      m_sw_prev = bus.sw_n;
      tracking  = m_since > LS;
      hit       = bus.host_wr && (hi == m_sel);
      mir       = tracking && !press && !hit && (co != m_param[m_sel]);
      hchg      = bus.host_wr && (m_param[hi] != int'(bus.host_data));
      m_chg     = mir || hchg;
      if (mir)       m_chg_idx = m_sel;
      else if (hchg) m_chg_idx = hi;
      if (bus.host_wr) m_param[hi] = int'(bus.host_data);
      if (mir)         m_param[m_sel] = co;
      if (tracking && press) m_sel = (m_sel + 1) % NP;
      if (hit || (tracking && press)) m_since = 0;
      else if (m_since <= LS)         m_since = m_since + 1;
    end
  end

  // Per-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin : compare
    logic [NP*CB-1:0] exp_params;
    if (model_ok) begin
      for (int k = 0; k < NP; k++) exp_params[k*CB +: CB] = CB'(m_param[k]);
      check("cmp_counter_init", 64'(bus.counter_init), 64'((m_since == 0) && !reset));
      check("cmp_busy",         64'(bus.busy),         64'(m_since <= LS));
      check("cmp_sel_idx",      64'(bus.sel_idx),      64'(m_sel));
      check("cmp_counter_in",   64'(bus.counter_in),   64'(m_param[m_sel]));
      check("cmp_params",       64'(bus.params),       64'(exp_params));
      check("cmp_param_changed", 64'(bus.param_changed), 64'(m_chg));
      if (m_chg) check("cmp_changed_idx", 64'(bus.changed_idx), 64'(m_chg_idx));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  int exp_sel [4] = '{1, 2, 3, 0};
  int exp_val [4] = '{0, 0, 0, 5};
  int ninit;

  initial begin
    reset           = 1'b1;
    bus.sw_n        = 1'b1;
    bus.counter_out = '0;
    bus.host_wr     = 1'b0;
    bus.host_idx    = '0;
    bus.host_data   = '0;

    step();
    model_ok = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    // First cycle out of reset is the load of parameter 0.
    check("rst_counter_init", 64'(bus.counter_init), 64'd1);
    check("rst_counter_in",   64'(bus.counter_in),   64'(INIT));
    check("rst_busy",         64'(bus.busy),         64'd1);
    check("rst_sel",          64'(bus.sel_idx),      64'd0);
    step();
    check("settle1_busy", 64'(bus.busy), 64'd1);
    check("settle1_init", 64'(bus.counter_init), 64'd0);
    step();
    check("settle2_busy", 64'(bus.busy), 64'd1);
    step();
    check("track_busy",    64'(bus.busy), 64'd0);
    check("track_nochg",   64'(bus.param_changed), 64'd0);

    // Encoder moves 0 -> 5 while tracking parameter 0.
    bus.counter_out = 8'h05;
    step();
    check("mirror_param0",  64'(bus.params[7:0]), 64'h05);
    check("mirror_changed", 64'(bus.param_changed), 64'd1);
    check("mirror_idx",     64'(bus.changed_idx), 64'd0);
    step();
    check("mirror_pulse_end", 64'(bus.param_changed), 64'd0);

    // Four held presses walk the selection 1,2,3,0.
    for (int i = 0; i < 4; i++) begin
      bus.sw_n = 1'b0;
      step();
      check("press_sel",        64'(bus.sel_idx), 64'(exp_sel[i]));
      check("press_counter_in", 64'(bus.counter_in), 64'(exp_val[i]));
      ninit = int'(bus.counter_init);
      bus.counter_out = CB'(exp_val[i]);
      repeat (49) begin
        step();
        ninit += int'(bus.counter_init);
      end
      check("press_init_count", 64'(ninit), 64'd1);
      bus.sw_n = 1'b1;
      step();
      step();
    end

    // Host write to an unselected register: no reload.
    bus.host_wr = 1'b1; bus.host_idx = 2'd2; bus.host_data = 8'h7F;
    step();
    bus.host_wr = 1'b0;
    check("host_param2",  64'(bus.params[23:16]), 64'h7F);
    check("host_no_init", 64'(bus.counter_init), 64'd0);
    check("host_changed", 64'(bus.param_changed), 64'd1);
    check("host_chg_idx", 64'(bus.changed_idx), 64'd2);

    // Move selection to 2, encoder following each load.
    for (int i = 0; i < 2; i++) begin
      bus.sw_n = 1'b0;
      step();
      bus.counter_out = (i == 0) ? 8'h00 : 8'h7F;
      bus.sw_n = 1'b1;
      repeat (5) step();
    end
    check("sel_is_2", 64'(bus.sel_idx), 64'd2);

    // Same write to the selected register forces a reload.
    bus.host_wr = 1'b1; bus.host_idx = 2'd2; bus.host_data = 8'h7F;
    step();
    bus.host_wr = 1'b0;
    check("hit_init",       64'(bus.counter_init), 64'd1);
    check("hit_counter_in", 64'(bus.counter_in), 64'h7F);
    check("hit_nochg",      64'(bus.param_changed), 64'd0);
    repeat (4) step();

    // Press while settling is dropped.
    bus.sw_n = 1'b0;
    step();
    bus.counter_out = 8'h00;
    bus.sw_n = 1'b1;
    step();
    bus.sw_n = 1'b0;
    step();
    check("settle_press_busy", 64'(bus.busy), 64'd1);
    check("settle_press_sel",  64'(bus.sel_idx), 64'd3);
    step();
    check("settle_press_track", 64'(bus.busy), 64'd0);
    repeat (3) step();
    check("held_no_advance", 64'(bus.sel_idx), 64'd3);
    bus.sw_n = 1'b1;
    step();

    // Host write to selected register collides with an encoder move.
    bus.counter_out = 8'h33;
    bus.host_wr = 1'b1; bus.host_idx = 2'd3; bus.host_data = 8'h44;
    step();
    bus.host_wr = 1'b0;
    bus.counter_out = 8'h44;
    check("collide_param3", 64'(bus.params[31:24]), 64'h44);
    check("collide_chg_idx", 64'(bus.changed_idx), 64'd3);
    check("collide_init",   64'(bus.counter_init), 64'd1);

    // Reset while settling with sel_idx=3.
    step();
    check("pre_reset_busy", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.counter_out = 8'h00;
    #1;
    check("reset_params", 64'(bus.params), 64'd0);
    check("reset_sel",    64'(bus.sel_idx), 64'd0);
    check("reset_load",   64'(bus.counter_init), 64'd1);
    step();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) bus.sw_n = ~bus.sw_n;
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 4))
          0: bus.counter_out = 8'h00;
          1: bus.counter_out = 8'hFF;
          2: bus.counter_out = 8'h7F;
          default: bus.counter_out = CB'($urandom);
        endcase
      end
      bus.host_wr   = ($urandom_range(0, 7) == 0);
      bus.host_idx  = IW'($urandom_range(0, NP - 1));
      bus.host_data = ($urandom_range(0, 1) == 0) ? bus.counter_out : CB'($urandom);
      reset         = ($urandom_range(0, 399) == 0);
      step();
    end
    reset       = 1'b0;
    bus.host_wr = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
